// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: ALU opcodes, RV32I
// opcodes, FSM states and datapath select values.
package ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR,
    S_LINK, S_LUI, S_AUIPC, S_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_BR, CLS_ADD} opclass_t;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MDR    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU opcode decode from opclass/funct3/funct7_5, plus the branch
// polarity bit (1 = branch taken when the ALU zero flag is set).
module alu_decoder
  import ctrl_pkg::*;
(
  input  opclass_t   opclass,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op,
  output logic       taken_on_zero
);

  always_comb begin
    alu_op        = ALU_ADD;
    taken_on_zero = 1'b0;
    case (opclass)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  alu_op = (opclass == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      CLS_BR: begin
        // SLT/SLTU yield 1 when "less", so zero means the GE variants are taken
        case (funct3)
          3'b000: begin alu_op = ALU_SUB;  taken_on_zero = 1'b1; end
          3'b001: begin alu_op = ALU_SUB;  taken_on_zero = 1'b0; end
          3'b100: begin alu_op = ALU_SLT;  taken_on_zero = 1'b0; end
          3'b101: begin alu_op = ALU_SLT;  taken_on_zero = 1'b1; end
          3'b110: begin alu_op = ALU_SLTU; taken_on_zero = 1'b0; end
          3'b111: begin alu_op = ALU_SLTU; taken_on_zero = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core (fetch/decode/execute/mem/wb).
// CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap and stick until rst; otherwise NOP.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [3:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       addr_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       illegal
);

  state_t     state, next_state;
  opclass_t   opclass;
  logic [3:0] dec_op;
  logic       taken_on_zero;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    case (state)
      S_EXEC_R: opclass = CLS_R;
      S_EXEC_I: opclass = CLS_I;
      S_BRANCH: opclass = CLS_BR;
      default:  opclass = CLS_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .opclass       (opclass),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .alu_op        (dec_op),
    .taken_on_zero (taken_on_zero)
  );

  always_comb begin
    next_state = state;
    alu_op     = ALU_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    addr_src   = ADDR_PC;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            result_src = RES_ALU;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          case (opcode)
            OPC_LOAD, OPC_STORE: next_state = S_MEM_ADR;
            OPC_OP:     next_state = S_EXEC_R;
            OPC_OP_IMM: next_state = S_EXEC_I;
            OPC_BRANCH: next_state = (funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
            OPC_JAL:    next_state = S_JAL;
            OPC_JALR:   next_state = S_JALR;
            OPC_LUI:    next_state = S_LUI;
            OPC_AUIPC:  next_state = S_AUIPC;
            default:    next_state = S_ILLEGAL;
          endcase
        end
        S_MEM_ADR: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          next_state = (opcode == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          addr_src = ADDR_ALUOUT;
          if (mem_ready) next_state = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          result_src = RES_MDR;
          next_state = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_src = ADDR_ALUOUT;
          if (mem_ready) next_state = S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a  = SRCA_RS1;
          alu_op     = dec_op;
          next_state = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          alu_op     = dec_op;
          next_state = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = SRCA_RS1;
          alu_op     = dec_op;
          pc_write   = (alu_zero == taken_on_zero);
          next_state = S_FETCH;
        end
        S_JAL: begin
          pc_write   = 1'b1;
          next_state = S_LINK;
        end
        S_JALR: begin
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_IMM;
          pc_write   = 1'b1;
          result_src = RES_ALU;
          next_state = S_LINK;
        end
        S_LINK: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          reg_write  = 1'b1;
          result_src = RES_ALU;
          next_state = S_FETCH;
        end
        S_LUI: begin
          alu_src_a  = SRCA_ZERO;
          alu_src_b  = SRCB_IMM;
          next_state = S_ALU_WB;
        end
        S_AUIPC: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_IMM;
          next_state = S_ALU_WB;
        end
        default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          next_state = S_ILLEGAL;
`else
          next_state = S_FETCH;
`endif
        end
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // set on entry so the flag is already high in the first ILLEGAL cycle
  always_ff @(posedge clk) begin
    if (rst)                          illegal_q <= 1'b0;
    else if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; per-cycle expected output words are hand-written.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [3:0] alu_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       addr_src, mem_req, mem_we, ir_write, pc_write, reg_write, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ev     [0:7];
  logic        rdy_v  [0:7];
  logic        zero_v [0:7];
  logic        rst_v  [0:7];
  logic [15:0] obs;
  logic [15:0] f_ok, f_wait, dec, wb, idle;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .addr_src   (addr_src),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {alu_op, alu_src_a, alu_src_b, result_src, addr_src,
                mem_req, mem_we, ir_write, pc_write, reg_write, illegal};

  function automatic logic [15:0] vec(input logic [3:0] op, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] rs,
                                      input logic addr, input logic req, input logic we,
                                      input logic ir, input logic pc, input logic rw,
                                      input logic il);
    return {op, a, b, rs, addr, req, we, ir, pc, rw, il};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic prep(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
    for (int i = 0; i < 8; i++) begin
      ev[i]     = 16'h0;
      rdy_v[i]  = 1'b1;
      zero_v[i] = 1'b0;
      rst_v[i]  = 1'b0;
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst       = rst_v[i];
      mem_ready = rdy_v[i];
      alu_zero  = zero_v[i];
      #1;
      check_eq($sformatf("%s_c%0d", tag, i + 1), obs, ev[i]);
    end
  endtask

  initial begin
    f_ok   = vec(0, 0, 2, 2, 0, 1, 0, 1, 1, 0, 0);
    f_wait = vec(0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    dec    = vec(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    wb     = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle   = 16'h0;

    // reset: all strobes low, ADD, even with mem_ready high
    prep(7'h33, 3'b000, 1'b0);
    rst_v[0] = 1; rst_v[1] = 1;
    run("reset", 2);

    prep(7'h33, 3'b000, 1'b0);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[3] = wb;
    run("add", 4);

    prep(7'h33, 3'b000, 1'b1);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); ev[3] = wb;
    run("sub", 4);

    prep(7'h13, 3'b000, 1'b1);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0); ev[3] = wb;
    run("addi", 4);

    prep(7'h13, 3'b101, 1'b1);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0); ev[3] = wb;
    run("srai", 4);

    // lw with two wait cycles in MEM_RD: 7 cycles total
    prep(7'h03, 3'b010, 1'b0);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    ev[3] = vec(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0); ev[4] = ev[3]; ev[5] = ev[3];
    ev[6] = vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    rdy_v[3] = 0; rdy_v[4] = 0;
    run("lw", 7);

    prep(7'h63, 3'b100, 1'b0);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(8, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    run("blt", 3);

    prep(7'h63, 3'b101, 1'b0);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run("bge", 3);

    prep(7'h63, 3'b000, 1'b0);
    zero_v[2] = 1;
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    run("beq", 3);

    prep(7'h67, 3'b000, 1'b0);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(0, 2, 1, 2, 0, 0, 0, 0, 1, 0, 0);
    ev[3] = vec(0, 1, 2, 2, 0, 0, 0, 0, 0, 1, 0);
    run("jalr", 4);

    prep(7'h37, 3'b000, 1'b0);
    ev[0] = f_ok; ev[1] = dec; ev[2] = vec(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0); ev[3] = wb;
    run("lui", 4);

    // sw: one fetch wait, then a reset while MEM_WR waits drops the write
    prep(7'h23, 3'b010, 1'b0);
    rdy_v[0] = 0; rdy_v[4] = 0; rdy_v[5] = 0; rst_v[5] = 1;
    ev[0] = f_wait; ev[1] = f_ok; ev[2] = dec; ev[3] = vec(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    ev[4] = vec(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0); ev[5] = idle;
    run("sw_rst", 6);

    prep(7'h7F, 3'b000, 1'b0);
    ev[0] = f_ok; ev[1] = dec;
`ifdef CTRL_ILLEGAL_TRAP_EN
    ev[2] = 16'h0001; ev[3] = 16'h0001; ev[4] = 16'h0001; ev[5] = 16'h0001;
    rst_v[5] = 1;
    run("illegal", 6);
`else
    ev[2] = idle;
    run("illegal", 3);
`endif

    // back in FETCH with the flag cleared
    prep(7'h33, 3'b000, 1'b0);
    ev[0] = f_ok; ev[1] = dec;
    run("post_ill", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM of the multicycle RV32I core. It sequences the shared 32-bit ALU, memory port, PC, IR and register file through fetch, decode, execute, memory and writeback, one ALU operation per cycle. It drives the ALU operation code and all datapath mux selects and write strobes, and consumes the opcode fields from the IR and the ALU `zero` flag.

## Interface
Parameters:
- none (encodings fixed in `ctrl_pkg`)

Ports:
- `clk`  in  1  core clock, single clock domain
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  7  IR[6:0]; valid from DECODE onward
- `funct3`  in  3  IR[14:12]
- `funct7_5`  in  1  IR[30]
- `alu_zero`  in  1  ALU zero flag, same cycle
- `mem_ready`  in  1  memory completes the current request this cycle
- `alu_op`  out  4  ALU opcode: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9
- `alu_src_a`  out  2  0 = PC, 1 = oldPC, 2 = rs1, 3 = zero
- `alu_src_b`  out  2  0 = rs2, 1 = imm, 2 = constant 4
- `result_src`  out  2  0 = ALUOut register, 1 = memory data register, 2 = live ALU result
- `addr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_req`  out  1  memory request
- `mem_we`  out  1  memory write (only with `mem_req`)
- `ir_write`  out  1  load IR and oldPC
- `pc_write`  out  1  PC <= result bus
- `reg_write`  out  1  rd <= result bus
- `illegal`  out  1  sticky illegal-instruction flag (tied 0 without macro)

## Operation
- Outputs are Moore functions of the state, except `pc_write` in BRANCH and the FETCH, MEM_RD and MEM_WR strobes gated by `mem_ready`.
- Defaults in every state: all strobes 0, `alu_op` = ADD, all selects 0.
- FETCH: `mem_req` = 1, `addr_src` = 0. `alu_src_a` = PC, `alu_src_b` = 4, ADD. Holds until `mem_ready`; in that cycle `ir_write` = 1 and `pc_write` = 1 with `result_src` = 2. Next state is DECODE.
- DECODE: `alu_src_a` = oldPC, `alu_src_b` = imm, ADD, so ALUOut holds the branch/JAL target. Dispatch on opcode:
  - LOAD / STORE -> MEM_ADR
  - OP -> EXEC_R
  - OP-IMM -> EXEC_I
  - BRANCH -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI -> LUI
  - AUIPC -> AUIPC
  - anything else -> ILLEGAL
- MEM_ADR: rs1 + imm. Next state MEM_RD for loads, MEM_WR for stores.
- MEM_RD: `mem_req` = 1, `addr_src` = 1. Waits for `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write` = 1, `result_src` = 1. Next state FETCH.
- MEM_WR: `mem_req` = 1, `mem_we` = 1, `addr_src` = 1. Waits for `mem_ready`, then FETCH.
- EXEC_R: rs1 op rs2. `alu_op` from funct3 (000 ADD/SUB by `funct7_5`, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by `funct7_5`, 110 OR, 111 AND). Next state ALU_WB.
- EXEC_I: rs1 op imm, same table, except `funct7_5` is honoured only for funct3 101; ADDI is never SUB. Next state ALU_WB.
- ALU_WB: `reg_write` = 1, `result_src` = 0. Next state FETCH.
- BRANCH: compares rs1 against rs2, `result_src` = 0, next state FETCH.
  - BEQ: SUB, taken = zero
  - BNE: SUB, taken = !zero
  - BLT: SLT, taken = !zero
  - BGE: SLT, taken = zero
  - BLTU: SLTU, taken = !zero
  - BGEU: SLTU, taken = zero
  - `pc_write` = taken
  - funct3 010/011 -> ILLEGAL
- JAL: `pc_write` = 1, `result_src` = 0 (target in ALUOut). Next state LINK.
- JALR: rs1 + imm, `pc_write` = 1, `result_src` = 2. Next state LINK. rs1 is consumed before rd is written, so rd == rs1 is safe.
- LINK: oldPC + 4, `reg_write` = 1, `result_src` = 2. Next state FETCH.
- LUI: zero + imm. Next state ALU_WB.
- AUIPC: oldPC + imm. Next state ALU_WB.

## Timing
- Reset: state <= FETCH and `illegal` <= 0. While `rst` = 1, every strobe output is forced to 0 and `alu_op` = ADD.
- Reset mid-operation aborts the instruction. An in-flight memory request is dropped with no write strobe.
- Cycle counts with zero-wait memory (`mem_ready` = 1 in its first cycle):
  - branch 3
  - R-type, I-type, LUI, AUIPC, JAL, JALR, store: 4
  - load 5
- Each wait cycle adds 1 to FETCH, MEM_RD or MEM_WR.
- `mem_req`, `mem_we` and `addr_src` stay stable until `mem_ready`.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: ILLEGAL sets `illegal` = 1, holds all strobes at 0 and stays in ILLEGAL until `rst`.
- `CTRL_ILLEGAL_TRAP_EN` undefined: ILLEGAL behaves as a NOP. It goes to FETCH the next cycle (PC already advanced) and `illegal` is constant 0.

## Structure
- `ctrl_pkg` holds:
  - ALU opcode localparams shared with the ALU
  - RV32I opcode constants
  - state encoding
  - select encodings for `alu_src_a`, `alu_src_b`, `result_src` and `addr_src`
- Sub-module `alu_decoder`: combinational; maps opclass (R, I, BRANCH, ADD), funct3 and `funct7_5` to `alu_op` plus the branch taken-polarity bit.

## Test plan
- `add x3,x1,x2` with `mem_ready` tied 1 -> FETCH, DECODE, EXEC_R (`alu_op` = 0), ALU_WB. `reg_write` pulses once in cycle 4 and `pc_write` pulses once in cycle 1.
- `sub` (funct7_5 = 1) -> `alu_op` = 1. `addi` with IR[30] = 1 -> `alu_op` = 0. `srai` -> `alu_op` = 7.
- `lw` with `mem_ready` low for 2 cycles in MEM_RD -> `mem_req`/`addr_src` = 1 held for 3 cycles, then MEM_WB with `result_src` = 1. Total 7 cycles.
- `blt` with `alu_zero` = 0 -> `pc_write` = 1 in BRANCH. `bge` with `alu_zero` = 0 -> `pc_write` = 0. Both take 3 cycles.
- `jalr x1,0(x1)` -> JALR has `pc_write` = 1 with `result_src` = 2; LINK has `reg_write` = 1 with `alu_src_a` = 1 and `alu_src_b` = 2.
- Opcode 0x7F then `rst` = 1 for one cycle:
  - with macro: `illegal` = 1 and all strobes 0 until reset, then FETCH with `illegal` = 0
  - without macro: returns to FETCH the next cycle
